// File: rtl/score_sequencer.sv
// Match controller for the two-player bouncer game: turns goal events into
// single-cycle count pulses, sequences serve/play/hold phases, and keeps a
// BCD shadow of both scores to declare the winner at WIN_SCORE.
module score_sequencer #(
   parameter int WIN_SCORE    = 11,
   parameter int SERVE_CYCLES = 25_000_000,
   parameter int HOLD_CYCLES  = 50_000_000,
   parameter int TIMER_W      = 26
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic goal1,
   input  logic goal2,
   output logic count1,
   output logic count2,
   output logic scores_clr,
   output logic ball_en,
   output logic serve_side,
   output logic game_over,
   output logic winner
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SERVE  = 3'd1,
      PLAY   = 3'd2,
      SCORED = 3'd3,
      HOLD   = 3'd4,
      OVER   = 3'd5
   } state_t;

   localparam logic [3:0]         WIN_TENS   = 4'(WIN_SCORE / 10);
   localparam logic [3:0]         WIN_UNITS  = 4'(WIN_SCORE % 10);
   localparam logic [TIMER_W-1:0] SERVE_LAST = TIMER_W'(SERVE_CYCLES - 1);
   localparam logic [TIMER_W-1:0] HOLD_LAST  = TIMER_W'(HOLD_CYCLES - 1);

   state_t             state_reg, state_next;
   logic [TIMER_W-1:0] timer_reg, timer_next;
   logic               start_prev_reg, goal1_prev_reg, goal2_prev_reg;
   logic               scorer_reg, scorer_next;
   logic               serve_side_reg, serve_side_next;
   logic               winner_reg, winner_next;
   logic [3:0]         tens_reg [2];
   logic [3:0]         units_reg [2];
   logic [3:0]         tens_next [2];
   logic [3:0]         units_next [2];
   logic [3:0]         inc_tens [2];
   logic [3:0]         inc_units [2];

   logic start_edge, goal1_edge, goal2_edge;
   logic win_hit;

   assign start_edge = start & ~start_prev_reg;
   assign goal1_edge = goal1 & ~goal1_prev_reg;
   assign goal2_edge = goal2 & ~goal2_prev_reg;

   // Saturating BCD increment of each player's shadow score, same digit
   // rules as the external accumulator so both stay in lock-step.
   for (genvar gi = 0; gi < 2; gi++) begin : g_bcd
      assign inc_units[gi] = (units_reg[gi] != 4'd9) ? units_reg[gi] + 4'd1 :
                             (tens_reg[gi]  != 4'd9) ? 4'd0 : 4'd9;
      assign inc_tens[gi]  = (units_reg[gi] != 4'd9) ? tens_reg[gi] :
                             (tens_reg[gi]  != 4'd9) ? tens_reg[gi] + 4'd1 : 4'd9;
   end

   assign win_hit = (inc_tens[scorer_reg] == WIN_TENS) &&
                    (inc_units[scorer_reg] == WIN_UNITS);

   assign serve_side = serve_side_reg;
   assign winner     = winner_reg;

   // Next-state and output decode; pulses are suppressed while rst is high
   // so a reset landing on a scoring cycle never leaks a count.
   always_comb begin
      state_next      = state_reg;
      scorer_next     = scorer_reg;
      serve_side_next = serve_side_reg;
      winner_next     = winner_reg;
      for (int i = 0; i < 2; i++) begin
         tens_next[i]  = tens_reg[i];
         units_next[i] = units_reg[i];
      end
      count1     = 1'b0;
      count2     = 1'b0;
      scores_clr = 1'b0;
      ball_en    = 1'b0;
      game_over  = 1'b0;

      case (state_reg)
         IDLE, OVER: begin
            game_over = (state_reg == OVER);
            if (start_edge) begin
               scores_clr      = 1'b1;
               serve_side_next = 1'b0;
               for (int i = 0; i < 2; i++) begin
                  tens_next[i]  = 4'd0;
                  units_next[i] = 4'd0;
               end
               state_next = SERVE;
            end
         end
         SERVE: begin
            if (timer_reg == SERVE_LAST) state_next = PLAY;
         end
         PLAY: begin
            ball_en = 1'b1;
            if (goal1_edge && goal2_edge) begin
               // Simultaneous goals cancel: replay the serve, no point.
               state_next = SERVE;
            end else if (goal1_edge) begin
               scorer_next = 1'b0;
               state_next  = SCORED;
            end else if (goal2_edge) begin
               scorer_next = 1'b1;
               state_next  = SCORED;
            end
         end
         SCORED: begin
            count1 = ~scorer_reg;
            count2 = scorer_reg;
            tens_next[scorer_reg]  = inc_tens[scorer_reg];
            units_next[scorer_reg] = inc_units[scorer_reg];
            if (win_hit) begin
               winner_next = scorer_reg;
               state_next  = OVER;
            end else begin
               // Next serve goes toward the player who conceded.
               serve_side_next = scorer_reg;
               state_next      = HOLD;
            end
         end
         HOLD: begin
            if (timer_reg == HOLD_LAST) state_next = SERVE;
         end
         default: state_next = IDLE;
      endcase

      if (rst) begin
         count1     = 1'b0;
         count2     = 1'b0;
         scores_clr = 1'b0;
      end
   end

   // Phase timer: restarts on every state change, only runs in timed phases.
   always_comb begin
      timer_next = '0;
      if (state_next == state_reg && (state_reg == SERVE || state_reg == HOLD))
         timer_next = timer_reg + 1'b1;
   end

   // State, timer, edge-detect and shadow-score registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         timer_reg      <= '0;
         start_prev_reg <= 1'b0;
         goal1_prev_reg <= 1'b0;
         goal2_prev_reg <= 1'b0;
         scorer_reg     <= 1'b0;
         serve_side_reg <= 1'b0;
         winner_reg     <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            tens_reg[i]  <= 4'd0;
            units_reg[i] <= 4'd0;
         end
      end else begin
         state_reg      <= state_next;
         timer_reg      <= timer_next;
         start_prev_reg <= start;
         goal1_prev_reg <= goal1;
         goal2_prev_reg <= goal2;
         scorer_reg     <= scorer_next;
         serve_side_reg <= serve_side_next;
         winner_reg     <= winner_next;
         for (int i = 0; i < 2; i++) begin
            tens_reg[i]  <= tens_next[i];
            units_reg[i] <= units_next[i];
         end
      end
   end

endmodule

// File: tb/tb_score_sequencer.sv
// Bench for score_sequencer: two instances (WIN_SCORE 11 and 99) share the
// stimulus and are compared every cycle against a phase/countdown model.
module tb_score_sequencer;

   localparam int SERVE = 4;
   localparam int HOLD  = 6;

   localparam int M_IDLE   = 0;
   localparam int M_SERVE  = 1;
   localparam int M_PLAY   = 2;
   localparam int M_SCORED = 3;
   localparam int M_HOLD   = 4;
   localparam int M_OVER   = 5;

   logic       clk = 1'b0;
   logic       rst, start, goal1, goal2;
   logic [1:0] count1, count2, scores_clr, ball_en, serve_side, game_over, winner;

   always #5 clk = ~clk;

   score_sequencer #(.WIN_SCORE(11), .SERVE_CYCLES(SERVE), .HOLD_CYCLES(HOLD), .TIMER_W(4)) u_dut11 (
      .clk(clk), .rst(rst), .start(start), .goal1(goal1), .goal2(goal2),
      .count1(count1[0]), .count2(count2[0]), .scores_clr(scores_clr[0]),
      .ball_en(ball_en[0]), .serve_side(serve_side[0]), .game_over(game_over[0]),
      .winner(winner[0]));

   score_sequencer #(.WIN_SCORE(99), .SERVE_CYCLES(SERVE), .HOLD_CYCLES(HOLD), .TIMER_W(4)) u_dut99 (
      .clk(clk), .rst(rst), .start(start), .goal1(goal1), .goal2(goal2),
      .count1(count1[1]), .count2(count2[1]), .scores_clr(scores_clr[1]),
      .ball_en(ball_en[1]), .serve_side(serve_side[1]), .game_over(game_over[1]),
      .winner(winner[1]));

   int checks   = 0;
   int failures = 0;

   // Reference model: phase name, cycles left in timed phase, integer scores.
   int win_cfg [2] = '{11, 99};
   int m_phase [2];
   int m_left [2];
   int m_pts [2][2];
   int m_scorer [2];
   int m_side [2];
   int m_winner [2];
   logic p_start, p_g1, p_g2;

   task automatic check_val(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_phase[i]  = M_IDLE;
         m_left[i]   = 0;
         m_pts[i][0] = 0;
         m_pts[i][1] = 0;
         m_scorer[i] = 0;
         m_side[i]   = 0;
         m_winner[i] = 0;
      end
      p_start = 1'b0;
      p_g1    = 1'b0;
      p_g2    = 1'b0;
   endtask

   task automatic check_outputs();
      logic se;
      se = start && !p_start;
      for (int i = 0; i < 2; i++) begin
         int e_c1, e_c2, e_clr;
         e_c1  = (!rst && m_phase[i] == M_SCORED && m_scorer[i] == 0) ? 1 : 0;
         e_c2  = (!rst && m_phase[i] == M_SCORED && m_scorer[i] == 1) ? 1 : 0;
         e_clr = (!rst && se && (m_phase[i] == M_IDLE || m_phase[i] == M_OVER)) ? 1 : 0;
         check_val($sformatf("count1[%0d]", i), int'(count1[i]), e_c1);
         check_val($sformatf("count2[%0d]", i), int'(count2[i]), e_c2);
         check_val($sformatf("scores_clr[%0d]", i), int'(scores_clr[i]), e_clr);
         check_val($sformatf("ball_en[%0d]", i), int'(ball_en[i]), (m_phase[i] == M_PLAY) ? 1 : 0);
         check_val($sformatf("game_over[%0d]", i), int'(game_over[i]), (m_phase[i] == M_OVER) ? 1 : 0);
         check_val($sformatf("serve_side[%0d]", i), int'(serve_side[i]), m_side[i]);
         if (m_phase[i] == M_OVER)
            check_val($sformatf("winner[%0d]", i), int'(winner[i]), m_winner[i]);
      end
   endtask

   task automatic step_model();
      logic se, e1, e2;
      if (rst) begin
         model_reset();
         return;
      end
      se = start && !p_start;
      e1 = goal1 && !p_g1;
      e2 = goal2 && !p_g2;
      for (int i = 0; i < 2; i++) begin
         case (m_phase[i])
            M_IDLE, M_OVER: begin
               if (se) begin
                  m_pts[i][0] = 0;
                  m_pts[i][1] = 0;
                  m_side[i]   = 0;
                  m_phase[i]  = M_SERVE;
                  m_left[i]   = SERVE;
               end
            end
            M_SERVE: begin
               m_left[i]--;
               if (m_left[i] == 0) m_phase[i] = M_PLAY;
            end
            M_PLAY: begin
               if (e1 && e2) begin
                  m_phase[i] = M_SERVE;
                  m_left[i]  = SERVE;
               end else if (e1 || e2) begin
                  m_scorer[i] = e1 ? 0 : 1;
                  m_phase[i]  = M_SCORED;
               end
            end
            M_SCORED: begin
               int s;
               s = m_pts[i][m_scorer[i]] + 1;
               if (s > 99) s = 99;
               m_pts[i][m_scorer[i]] = s;
               $display("dut%0d point to p%0d score %0d-%0d", i, m_scorer[i] + 1,
                        m_pts[i][0], m_pts[i][1]);
               if (s == win_cfg[i]) begin
                  m_winner[i] = m_scorer[i];
                  m_phase[i]  = M_OVER;
               end else begin
                  m_side[i]  = m_scorer[i];
                  m_phase[i] = M_HOLD;
                  m_left[i]  = HOLD;
               end
            end
            M_HOLD: begin
               m_left[i]--;
               if (m_left[i] == 0) begin
                  m_phase[i] = M_SERVE;
                  m_left[i]  = SERVE;
               end
            end
            default: m_phase[i] = M_IDLE;
         endcase
      end
      p_start = start;
      p_g1    = goal1;
      p_g2    = goal2;
   endtask

   task automatic cycle(input logic r, input logic s, input logic a, input logic b);
      @(negedge clk);
      rst   = r;
      start = s;
      goal1 = a;
      goal2 = b;
      #1;
      check_outputs();
      step_model();
   endtask

   // Idle cycles with goals low until instance 0 is about to be in PLAY.
   task automatic run_to_play();
      for (int k = 0; k < 40 && m_phase[0] != M_PLAY; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      logic na, nb, ns, nr;
      int   r;
      int   n99;

      rst = 1'b1; start = 1'b0; goal1 = 1'b0; goal2 = 1'b0;
      repeat (2) @(posedge clk);
      model_reset();

      // Reset state, then a start pulse (clear pulse, serve, play after 4)
      repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      check_val("t1_clr", int'(scores_clr[0]), 1);
      run_to_play();
      // goal1 held for 10 cycles: one count1 pulse only
      for (int k = 0; k < 10; k++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      run_to_play();
      // Simultaneous goals: no point, back to serve
      cycle(1'b0, 1'b0, 1'b1, 1'b1);
      check_val("t3_play", int'(ball_en[0]), 1);
      cycle(1'b0, 1'b0, 1'b1, 1'b1);
      check_val("t3_serve", int'(ball_en[0]), 0);
      check_val("t3_nocount", int'(count1[0] | count2[0]), 0);

      // Reset landing on the scoring cycle
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      run_to_play();
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 1'b0);
      check_val("t5_scored_rst", int'(count1[0]), 0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      check_val("t5_after_rst", int'(game_over[0] | ball_en[0] | serve_side[0]), 0);
      // Reset in HOLD
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      run_to_play();
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      check_val("t5_hold_rst_side", int'(serve_side[0]), 0);

      // Random play: sections without and then with random resets
      for (int k = 0; k < 5000; k++) begin
         r  = $urandom_range(0, 15);
         na = goal1;
         nb = goal2;
         case (r)
            0: na = ~na;
            1: nb = ~nb;
            2: begin na = 1'b1; nb = 1'b1; end
            3: begin na = 1'b0; nb = 1'b0; end
            default: ;
         endcase
         ns = ($urandom_range(0, 59) == 0);
         nr = (k >= 3000) && ($urandom_range(0, 149) == 0);
         cycle(nr, ns, na, nb);
      end

      // Player 1 runs to 99 on the WIN_SCORE=99 instance
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      n99 = 0;
      for (int k = 0; k < 4000 && m_phase[1] != M_OVER; k++) begin
         cycle(1'b0, 1'b0, ~goal1, 1'b0);
         if (count1[1] === 1'b1) n99++;
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      check_val("t6_over", int'(game_over[1]), 1);
      check_val("t6_winner", int'(winner[1]), 0);
      check_val("t6_pulses", n99, 99);
      check_val("t4_over11", int'(game_over[0]), 1);
      // Goal edges after the match give nothing
      repeat (6) cycle(1'b0, 1'b0, ~goal1, ~goal1);
      // Restart clears
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      check_val("t6_restart_clr", int'(scores_clr[1]), 1);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      check_val("t6_restart_over", int'(game_over[1]), 0);
      run_to_play();
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      repeat (4) cycle(1'b0, 1'b0, 1'b0, 1'b0);
      check_val("t6_shadow_zeroed", int'(game_over[1]), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
